// File: rtl/text_tty.sv
`default_nettype none
// text_tty: teletype front-end for 80x25 text mode; writes char/attribute pairs into text RAM,
// interprets CR/LF/BS/FF and scrolls the screen. Scrolling is compiled in when TTY_SCROLL_EN is defined.
module text_tty #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 25,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    input  logic [7:0]  ch_attr,
    output logic        ch_busy,
    output logic [12:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  cursor_x,
    output logic [7:0]  cursor_y
);

    localparam logic [7:0]  LAST_COL    = 8'(COLS - 1);
    localparam logic [7:0]  LAST_ROW    = 8'(ROWS - 1);
    localparam logic [12:0] SCREEN_LAST = 13'(2 * COLS * ROWS - 1);
`ifdef TTY_SCROLL_EN
    localparam logic [12:0] ROW_BYTES   = 13'(2 * COLS);
    localparam logic [12:0] MOVE_LAST   = 13'(2 * COLS * (ROWS - 1) - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PUT_CH,
        PUT_AT,
        CTRL,
        CLR
`ifdef TTY_SCROLL_EN
        ,
        SCR_RD,
        SCR_WR,
        FILL
`endif
    } state_t;

    state_t      state, state_next;
    logic [12:0] addr_reg, addr_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic        we_reg, we_next;
    logic [7:0]  x_next, y_next;
    logic [7:0]  attr_reg;
    logic        advance_row;
    logic [12:0] cell_addr;

    assign cell_addr   = (13'(cursor_y) * 13'(COLS) + 13'(cursor_x)) << 1;
    assign ch_busy     = (state != IDLE);
    assign mem_address = addr_reg;
    assign mem_we      = we_reg;

`ifdef TTY_SCROLL_EN
    // During a scroll write the moved byte comes straight from the RAM read port.
    assign mem_wdata = (state == SCR_WR) ? mem_rdata : wdata_reg;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign mem_wdata    = wdata_reg;
`endif

    always_comb begin
        state_next  = state;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        we_next     = we_reg;
        x_next      = cursor_x;
        y_next      = cursor_y;
        advance_row = 1'b0;
        case (state)
            IDLE: begin
                we_next = 1'b0;
                if (ch_valid) begin
                    if (ch_data >= 8'h20) begin
                        state_next = PUT_CH;
                        addr_next  = cell_addr;
                        wdata_next = ch_data;
                        we_next    = 1'b1;
                    end else if (ch_data == 8'h0C) begin
                        state_next = CLR;
                        addr_next  = '0;
                        wdata_next = FILL_CHAR;
                        we_next    = 1'b1;
                        x_next     = '0;
                        y_next     = '0;
                    end else begin
                        state_next = CTRL;
                        case (ch_data)
                            8'h0D: x_next = '0;
                            8'h0A: begin
                                x_next      = '0;
                                advance_row = 1'b1;
                            end
                            8'h08: if (cursor_x != 8'd0) x_next = cursor_x - 8'd1;
                            default: ;
                        endcase
                    end
                end
            end
            PUT_CH: begin
                state_next = PUT_AT;
                addr_next  = addr_reg + 13'd1;
                wdata_next = attr_reg;
            end
            PUT_AT: begin
                state_next = IDLE;
                we_next    = 1'b0;
                if (cursor_x == LAST_COL) begin
                    x_next      = '0;
                    advance_row = 1'b1;
                end else begin
                    x_next = cursor_x + 8'd1;
                end
            end
            CTRL: state_next = IDLE;
`ifdef TTY_SCROLL_EN
            SCR_RD: begin
                state_next = SCR_WR;
                addr_next  = addr_reg - ROW_BYTES;
                we_next    = 1'b1;
            end
            SCR_WR: begin
                if (addr_reg == MOVE_LAST) begin
                    state_next = FILL;
                    addr_next  = addr_reg + 13'd1;
                    wdata_next = FILL_CHAR;
                end else begin
                    state_next = SCR_RD;
                    addr_next  = addr_reg + ROW_BYTES + 13'd1;
                    we_next    = 1'b0;
                end
            end
            FILL, CLR: begin
`else
            CLR: begin
`endif
                // Even addresses hold characters, odd addresses attributes.
                if (addr_reg == SCREEN_LAST) begin
                    state_next = IDLE;
                    we_next    = 1'b0;
                end else begin
                    addr_next  = addr_reg + 13'd1;
                    wdata_next = addr_reg[0] ? FILL_CHAR : attr_reg;
                end
            end
            default: state_next = IDLE;
        endcase

        if (advance_row) begin
            if (cursor_y != LAST_ROW) begin
                y_next = cursor_y + 8'd1;
            end else begin
`ifdef TTY_SCROLL_EN
                state_next = SCR_RD;
                addr_next  = ROW_BYTES;
                we_next    = 1'b0;
`else
                y_next = '0;
`endif
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            attr_reg  <= '0;
        end else begin
            state     <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            we_reg    <= we_next;
            cursor_x  <= x_next;
            cursor_y  <= y_next;
            if (state == IDLE && ch_valid) attr_reg <= ch_attr;
        end
    end

endmodule
`default_nettype wire
